// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: default widths and the read-stream
// occupancy state type.
package fifo_pkg;

    localparam int FIFO_DSIZE  = 8;
    localparam int FIFO_ASIZE  = 3;
    localparam int FIFO_CWIDTH = 16;

    // Read-stream buffer state, encoded directly as the number of held words.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_stream.sv
// Turns a first-word-fall-through FIFO read port into a valid/ready stream
// through a 2-entry skid buffer, counting every word accepted downstream.
//
// state    | meaning
// ST_EMPTY | no word buffered, o_m_valid low
// ST_ONE   | head holds the only word
// ST_TWO   | head and tail both hold words, popping is blocked
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE  = FIFO_DSIZE,
    parameter int CWIDTH = FIFO_CWIDTH
) (
    input  logic              i_rclk,
    input  logic              i_rrst_n,
    input  logic [DSIZE-1:0]  i_fifo_rdata,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd,
    output logic [DSIZE-1:0]  o_m_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    input  logic              i_flush,
    output logic [CWIDTH-1:0] o_rd_count
);

    rd_state_t         state;
    logic [DSIZE-1:0]  head;
    logic [DSIZE-1:0]  tail;
    logic [CWIDTH-1:0] count;
    logic              pop;
    logic              accept;

    // Gating with the reset pin keeps the pop strobe low the moment reset asserts,
    // without waiting for a clock edge. i_m_ready never reaches the pop strobe.
    assign pop    = i_rrst_n && !i_fifo_empty && !i_flush && (state != ST_TWO);
    assign accept = (state != ST_EMPTY) && i_m_ready;

    assign o_fifo_rd  = pop;
    assign o_m_valid  = (state != ST_EMPTY);
    assign o_m_data   = (state != ST_EMPTY) ? head : '0;
    assign o_rd_count = count;

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                count <= count + CWIDTH'(1);
            end

            if (i_flush) begin
                state <= ST_EMPTY;
                head  <= '0;
                tail  <= '0;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (pop) begin
                            head  <= i_fifo_rdata;
                            state <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (pop && accept) begin
                            head <= i_fifo_rdata;
                        end else if (pop) begin
                            tail  <= i_fifo_rdata;
                            state <= ST_TWO;
                        end else if (accept) begin
                            state <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (accept) begin
                            head  <= tail;
                            state <= ST_ONE;
                        end
                    end
                    default: begin
                        state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an upstream FIFO queue and a queue-based buffer model
// predict every output; directed scenarios plus a randomized run.
module tb_fifo_rd_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  fifo_rdata;
    logic        fifo_empty;
    logic        m_ready;
    logic        flush;
    logic        fifo_rd;
    logic [7:0]  m_data;
    logic        m_valid;
    logic [15:0] rd_count;
    logic        fifo_rd4;
    logic [7:0]  m_data4;
    logic        m_valid4;
    logic [3:0]  rd_count4;

    int vectors;
    int miscompares;

    logic [7:0]  upq[$];
    logic [7:0]  mbuf[$];
    logic [7:0]  got[$];
    int unsigned mcount;
    int          pop_cnt;
    int          cyc;

    fifo_rd_stream dut (
        .i_rclk(clk), .i_rrst_n(rst_n), .i_fifo_rdata(fifo_rdata),
        .i_fifo_empty(fifo_empty), .o_fifo_rd(fifo_rd), .o_m_data(m_data),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .i_flush(flush),
        .o_rd_count(rd_count)
    );

    fifo_rd_stream #(.DSIZE(8), .CWIDTH(4)) dut4 (
        .i_rclk(clk), .i_rrst_n(rst_n), .i_fifo_rdata(fifo_rdata),
        .i_fifo_empty(fifo_empty), .o_fifo_rd(fifo_rd4), .o_m_data(m_data4),
        .o_m_valid(m_valid4), .i_m_ready(m_ready), .i_flush(flush),
        .o_rd_count(rd_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: apply inputs at the falling edge, compare against the
    // queue model, then advance both the upstream FIFO and the model.
    task automatic model_cycle(input logic ready, input logic flsh);
        logic       exp_rd;
        logic       acc;
        logic       dut_pop;
        logic [7:0] exp_data;
        logic [7:0] head_word;
        m_ready    = ready;
        flush      = flsh;
        fifo_empty = (upq.size() == 0);
        fifo_rdata = fifo_empty ? 8'($urandom) : upq[0];
        #1;
        exp_rd   = rst_n && (upq.size() != 0) && !flsh && (mbuf.size() < 2);
        exp_data = (mbuf.size() != 0) ? mbuf[0] : 8'h00;
        vectors++;
        if (fifo_rd !== exp_rd) begin
            miscompares++;
            $display("FAIL fifo_rd cyc=%0d got=%b exp=%b", cyc, fifo_rd, exp_rd);
        end
        vectors++;
        if (m_valid !== (mbuf.size() != 0)) begin
            miscompares++;
            $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, mbuf.size() != 0);
        end
        vectors++;
        if (m_data !== exp_data) begin
            miscompares++;
            $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, m_data, exp_data);
        end
        vectors++;
        if (rd_count !== mcount[15:0]) begin
            miscompares++;
            $display("FAIL rd_count cyc=%0d got=%0d exp=%0d", cyc, rd_count, mcount[15:0]);
        end
        vectors++;
        if (rd_count4 !== mcount[3:0]) begin
            miscompares++;
            $display("FAIL rd_count4 cyc=%0d got=%0d exp=%0d", cyc, rd_count4, mcount[3:0]);
        end
        if (m_valid && ready) got.push_back(m_data);
        acc       = rst_n && (mbuf.size() != 0) && ready;
        head_word = fifo_rdata;
        dut_pop   = fifo_rd;
        @(posedge clk);
        if (rst_n) begin
            if (acc) mcount++;
            if (flsh) begin
                mbuf.delete();
            end else begin
                if (acc) void'(mbuf.pop_front());
                if (exp_rd) mbuf.push_back(head_word);
            end
        end
        if (dut_pop && upq.size() != 0) begin
            void'(upq.pop_front());
            pop_cnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        m_ready    = 1'b0;
        flush      = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = 8'h00;
        upq.delete();
        mbuf.delete();
        got.delete();
        mcount  = 0;
        pop_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        fifo_empty = 1'b0;
        fifo_rdata = 8'h77;
        m_ready    = 1'b1;
        #1;
        vectors++;
        if (fifo_rd !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || rd_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got rd=%b v=%b d=%h c=%0d exp 0,0,00,0", fifo_rd, m_valid, m_data, rd_count);
        end
        do_reset();
        for (int i = 0; i < 10; i++) model_cycle(1'($urandom_range(0, 1)), 1'b0);
        vectors++;
        if (fifo_rd !== 1'b0 || m_valid !== 1'b0 || rd_count !== 16'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset got rd=%b v=%b c=%0d exp 0,0,0", fifo_rd, m_valid, rd_count);
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp4 [4];
        exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        upq = '{8'h11, 8'h22, 8'h33, 8'h44};
        model_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (m_valid !== 1'b1 || m_data !== exp4[i]) begin
                miscompares++;
                $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, exp4[i]);
            end
            model_cycle(1'b1, 1'b0);
        end
        vectors++;
        if (m_valid !== 1'b0 || rd_count !== 16'd4) begin
            miscompares++;
            $display("FAIL stream_end got v=%b c=%0d exp v=0 c=4", m_valid, rd_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp4 [4];
        exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        upq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 5; i++) begin
            model_cycle(1'b0, 1'b0);
            vectors++;
            if (m_valid !== 1'b1 || m_data !== 8'h11) begin
                miscompares++;
                $display("FAIL hold_head cyc%0d got v=%b d=%h exp v=1 d=11", i, m_valid, m_data);
            end
        end
        vectors++;
        if (pop_cnt !== 2) begin
            miscompares++;
            $display("FAIL stall_pops got %0d exp 2", pop_cnt);
        end
        for (int i = 0; i < 6; i++) model_cycle(1'b1, 1'b0);
        vectors++;
        if (got.size() !== 4) begin
            miscompares++;
            $display("FAIL bp_count got %0d exp 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got[i] !== exp4[i]) begin
                    miscompares++;
                    $display("FAIL bp_order%0d got %h exp %h", i, got[i], exp4[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        upq = '{8'hA5, 8'h5A};
        model_cycle(1'b0, 1'b0);
        model_cycle(1'b0, 1'b0);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL two_head got v=%b d=%h exp v=1 d=a5", m_valid, m_data);
        end
        model_cycle(1'b0, 1'b1);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_valid got %b exp 0", m_valid);
        end
        for (int i = 0; i < 4; i++) model_cycle(1'b1, 1'b0);
        vectors++;
        if (got.size() !== 0 || rd_count !== 16'd0) begin
            miscompares++;
            $display("FAIL flush_discard got words=%0d c=%0d exp 0,0", got.size(), rd_count);
        end
        // accept coincident with flush still counts
        upq = '{8'h01, 8'h02, 8'h03};
        model_cycle(1'b1, 1'b0);
        model_cycle(1'b1, 1'b1);
        vectors++;
        if (rd_count !== 16'd1 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_accept got c=%0d v=%b exp c=1 v=0", rd_count, m_valid);
        end
        for (int i = 0; i < 5; i++) model_cycle(1'b1, 1'b0);
        vectors++;
        if (got.size() !== 3 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03) begin
            miscompares++;
            $display("FAIL flush_accept_order got n=%0d exp 01,02,03", got.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) upq.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) model_cycle(1'b1, 1'b0);
        vectors++;
        if (rd_count4 !== 4'd1 || rd_count !== 16'd17) begin
            miscompares++;
            $display("FAIL wrap got c4=%0d c16=%0d exp 1,17", rd_count4, rd_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        upq = '{8'hC1, 8'hC2, 8'hC3};
        model_cycle(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        mbuf.delete();
        mcount = 0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_rd !== 1'b0 || rd_count !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b d=%h rd=%b c=%0d exp 0,00,0,0", m_valid, m_data, fifo_rd, rd_count);
        end
        model_cycle(1'b1, 1'b0);
        rst_n = 1'b1;
        got.delete();
        for (int i = 0; i < 6; i++) model_cycle(1'b1, 1'b0);
        vectors++;
        if (got.size() !== 2 || got[0] !== 8'hC2 || got[1] !== 8'hC3) begin
            miscompares++;
            $display("FAIL post_reset_order got n=%0d exp c2,c3", got.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (upq.size() < 8 && $urandom_range(0, 99) < 60) upq.push_back(8'($urandom));
            model_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);
        end
        for (int i = 0; i < 20; i++) model_cycle(1'b1, 1'b0);
        vectors++;
        if (m_valid !== 1'b0 || upq.size() !== 0) begin
            miscompares++;
            $display("FAIL random_drain got v=%b left=%0d exp 0,0", m_valid, upq.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        mcount      = 0;
        pop_cnt     = 0;
        rst_n       = 1'b0;
        m_ready     = 1'b0;
        flush       = 1'b0;
        fifo_empty  = 1'b1;
        fifo_rdata  = 8'h00;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
